// File: rtl/rv32i_prefetch_pkg.sv
// Shared types and instantiation defaults for the rv32i instruction prefetch front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rv32i_prefetch_pkg;

    // Defaults used when the prefetch unit is instantiated without overrides.
    localparam int          PREFETCH_DEPTH       = 4;
    localparam int          PREFETCH_OUTSTANDING = 2;
    localparam logic [31:0] PREFETCH_PC_RESET    = 32'h0000_0000;

    // One buffered instruction together with the address it was fetched from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    // Trap redirects outrank branch redirects when both fire together.
    function automatic logic [31:0] redirect_target(
        input logic        wb_change,
        input logic [31:0] wb_pc,
        input logic [31:0] alu_pc
    );
        return wb_change ? wb_pc : alu_pc;
    endfunction

endpackage

// File: rtl/rv32i_sync_fifo.sv
// Synchronous FIFO holding fetched {pc, inst} entries behind the prefetch output register.
// Latency: a pushed entry is visible at pop_dat one cycle after the push.
// Backpressure: push is ignored when full, pop is ignored when empty; clear empties it in one cycle.
// Ports: clk/rst_n (async active-low), push/push_dat, pop/pop_dat, clear, full, empty, count.
module rv32i_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_dat,
    input  logic                       clear,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (!do_push && do_pop) count <= count - CW'(1);
        end
    end

    // Storage needs no reset: entries are only read once the pointers say they are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/rv32i_prefetch.sv
// rv32i instruction prefetch: pipelined fetch requests, {pc, inst} buffering, one instruction per cycle out.
// Latency: ack at edge N appears on o_ce/o_pc/o_inst after edge N when the output register is free.
// Backpressure: i_stall holds the output; requests stop once buffered + in-flight reaches DEPTH (credit), so no ack is ever dropped.
// Ports: o_iaddr/o_stb_inst request, i_ack_inst/i_inst response, i_writeback_*/i_alu_* redirects,
//        i_stall from decoder, o_ce/o_pc/o_inst presented instruction, o_count buffered entries.
module rv32i_prefetch
    import rv32i_prefetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET    = PREFETCH_PC_RESET,
    parameter int          DEPTH       = PREFETCH_DEPTH,
    parameter int          OUTSTANDING = PREFETCH_OUTSTANDING
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    output logic [31:0]              o_iaddr,
    output logic                     o_stb_inst,
    input  logic                     i_ack_inst,
    input  logic [31:0]              i_inst,
    input  logic                     i_writeback_change_pc,
    input  logic [31:0]              i_writeback_next_pc,
    input  logic                     i_alu_change_pc,
    input  logic [31:0]              i_alu_next_pc,
    input  logic                     i_stall,
    output logic                     o_ce,
    output logic [31:0]              o_pc,
    output logic [31:0]              o_inst,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int             CW  = $clog2(DEPTH) + 1;
    localparam int             QD  = DEPTH - 1;          // queue sits behind the output register
    localparam int             QCW = $clog2(QD + 1);
    localparam logic [CW-1:0]  ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0]  inflight;   // all requests issued and not yet acked, stale ones included
    logic [CW-1:0]  discard;    // how many of those belong to a flushed stream
    logic [31:0]    ack_pc;     // pc of the next non-discarded response

    logic           redirect;
    logic [31:0]    target;
    logic [CW-1:0]  occ;
    logic [CW:0]    demand;
    logic           consume;
    logic           accept;
    logic           out_free;
    logic           load_ack;
    logic           q_push;
    logic           q_pop;
    logic           q_full;
    logic           q_empty;
    logic [QCW-1:0] q_count;
    fetch_entry_t   q_head;
    fetch_entry_t   ack_entry;

    assign redirect  = i_writeback_change_pc | i_alu_change_pc;
    assign target    = redirect_target(i_writeback_change_pc, i_writeback_next_pc, i_alu_next_pc);

    // Credit check counts every outstanding request, so each future ack has a slot waiting.
    assign occ       = CW'(q_count) + CW'(o_ce);
    assign demand    = {1'b0, occ} + {1'b0, inflight};
    assign o_stb_inst = i_rst_n && !redirect
                        && (inflight < CW'(OUTSTANDING))
                        && (demand < (CW+1)'(DEPTH));

    assign consume   = o_ce && !i_stall;
    assign accept    = i_ack_inst && (discard == '0);
    assign out_free  = !o_ce || consume;
    // An ack may bypass the queue only if nothing older is waiting in it.
    assign load_ack  = out_free && q_empty && accept;
    assign q_push    = accept && !load_ack && !redirect && !q_full;
    assign q_pop     = out_free && !q_empty && !redirect;
    assign ack_entry = '{pc: ack_pc, inst: i_inst};

    rv32i_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (QD)
    ) u_queue (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .push     (q_push),
        .push_dat (ack_entry),
        .pop      (q_pop),
        .pop_dat  (q_head),
        .clear    (redirect),
        .full     (q_full),
        .empty    (q_empty),
        .count    (q_count)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_iaddr  <= PC_RESET;
            ack_pc   <= PC_RESET;
            inflight <= '0;
            discard  <= '0;
            o_ce     <= 1'b0;
            o_pc     <= '0;
            o_inst   <= '0;
            o_count  <= '0;
        end else begin
            case ({o_stb_inst, i_ack_inst})
                2'b10:   inflight <= inflight + ONE;
                2'b01:   inflight <= inflight - ONE;
                default: ;
            endcase

            if (redirect) begin
                o_iaddr <= target;
                ack_pc  <= target;
                o_ce    <= 1'b0;
                o_count <= '0;
                // Everything still outstanding after this edge belongs to the old stream.
                discard <= inflight - CW'(i_ack_inst);
            end else begin
                if (o_stb_inst) o_iaddr <= o_iaddr + 32'd4;
                if (i_ack_inst && (discard != '0)) discard <= discard - ONE;
                if (accept) ack_pc <= ack_pc + 32'd4;

                if (out_free) begin
                    if (!q_empty) begin
                        o_ce   <= 1'b1;
                        o_pc   <= q_head.pc;
                        o_inst <= q_head.inst;
                    end else if (accept) begin
                        o_ce   <= 1'b1;
                        o_pc   <= ack_pc;
                        o_inst <= i_inst;
                    end else begin
                        o_ce   <= 1'b0;
                    end
                end

                case ({accept, consume})
                    2'b10:   o_count <= o_count + CW'(1);
                    2'b01:   o_count <= o_count - CW'(1);
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rv32i_prefetch.sv
// Bench for rv32i_prefetch: randomized bus/stall/redirect stimulus against a queue-level reference model.
// The model tracks requests by stream epoch and the decoder-visible instruction stream as a queue of PCs.
module tb_rv32i_prefetch;

    localparam logic [31:0] PCR   = 32'h0000_0100;
    localparam int          DEPTH = 4;
    localparam int          OUTS  = 2;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic [31:0] o_iaddr;
    logic        o_stb_inst;
    logic        i_ack_inst;
    logic [31:0] i_inst;
    logic        i_writeback_change_pc;
    logic [31:0] i_writeback_next_pc;
    logic        i_alu_change_pc;
    logic [31:0] i_alu_next_pc;
    logic        i_stall;
    logic        o_ce;
    logic [31:0] o_pc;
    logic [31:0] o_inst;
    logic [2:0]  o_count;

    always #5 clk = ~clk;

    rv32i_prefetch #(
        .PC_RESET    (PCR),
        .DEPTH       (DEPTH),
        .OUTSTANDING (OUTS)
    ) dut (
        .i_clk                 (clk),
        .i_rst_n               (i_rst_n),
        .o_iaddr               (o_iaddr),
        .o_stb_inst            (o_stb_inst),
        .i_ack_inst            (i_ack_inst),
        .i_inst                (i_inst),
        .i_writeback_change_pc (i_writeback_change_pc),
        .i_writeback_next_pc   (i_writeback_next_pc),
        .i_alu_change_pc       (i_alu_change_pc),
        .i_alu_next_pc         (i_alu_next_pc),
        .i_stall               (i_stall),
        .o_ce                  (o_ce),
        .o_pc                  (o_pc),
        .o_inst                (o_inst),
        .o_count               (o_count)
    );

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    req_t        bus[$];        // requests the memory still owes a response for
    logic [31:0] buf_q[$];      // PCs the front end holds for the decoder, oldest first
    logic [31:0] fetch_addr;
    int          epoch = 0;
    int          min_lat = 1;
    int          max_lat = 1;
    int          ack_pct = 100;
    bit          s_ce;
    logic [31:0] s_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: entered at posedge+1, drives inputs, checks outputs mid-cycle, advances the model.
    task automatic step(input bit stall, input bit wb, input logic [31:0] wb_pc,
                        input bit alu, input logic [31:0] alu_pc);
        bit          ack;
        bit          redir;
        bit          exp_stb;
        logic [31:0] tgt;
        req_t        r;
        ack = (bus.size() > 0) && (bus[0].due <= cyc) && ($urandom_range(99) < ack_pct);
        i_ack_inst            = ack;
        i_inst                = ack ? mem_word(bus[0].addr) : $urandom;
        i_stall               = stall;
        i_writeback_change_pc = wb;
        i_writeback_next_pc   = wb ? wb_pc : $urandom;
        i_alu_change_pc       = alu;
        i_alu_next_pc         = alu ? alu_pc : $urandom;
        #4;
        redir   = wb || alu;
        tgt     = wb ? wb_pc : alu_pc;
        exp_stb = !redir && (bus.size() < OUTS) && (buf_q.size() + bus.size() < DEPTH);
        chk("stb", 32'(o_stb_inst), 32'(exp_stb));
        if (exp_stb) chk("iaddr", o_iaddr, fetch_addr);
        chk("count", 32'(o_count), buf_q.size());
        chk("ce", 32'(o_ce), 32'(buf_q.size() > 0));
        if (buf_q.size() > 0) begin
            chk("pc", o_pc, buf_q[0]);
            chk("inst", o_inst, mem_word(buf_q[0]));
        end
        s_ce = o_ce;
        s_pc = o_pc;
        if (redir) begin
            if (ack) r = bus.pop_front();
            buf_q.delete();
            fetch_addr = tgt;
            epoch++;
        end else begin
            if (buf_q.size() > 0 && !stall) void'(buf_q.pop_front());
            if (ack) begin
                r = bus.pop_front();
                if (r.epoch == epoch) buf_q.push_back(r.addr);
            end
            if (exp_stb) begin
                r.addr  = fetch_addr;
                r.epoch = epoch;
                r.due   = cyc + int'($urandom_range(max_lat, min_lat));
                bus.push_back(r);
                fetch_addr = fetch_addr + 32'd4;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          n;
        bit          found;
        logic [31:0] first;

        i_rst_n = 1'b0;
        i_ack_inst = 1'b0; i_inst = '0; i_stall = 1'b0;
        i_writeback_change_pc = 1'b0; i_writeback_next_pc = '0;
        i_alu_change_pc = 1'b0; i_alu_next_pc = '0;
        fetch_addr = PCR;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_iaddr", o_iaddr, PCR);
        chk("rst_stb",   32'(o_stb_inst), 32'd0);
        chk("rst_ce",    32'(o_ce), 32'd0);
        chk("rst_pc",    o_pc, 32'd0);
        chk("rst_inst",  o_inst, 32'd0);
        chk("rst_count", 32'(o_count), 32'd0);
        i_rst_n = 1'b1;

        // Zero-wait bus, no stall: one instruction per cycle once primed.
        repeat (6) step(0, 0, 0, 0, 0);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 0, 0, 0);
            if (s_ce) n++;
        end
        chk("zero_wait_rate", n, 12);

        // Stall until the credit limit is hit, then drain in order.
        repeat (10) step(1, 0, 0, 0, 0);
        chk("stall_full_count", 32'(o_count), DEPTH);
        chk("stall_no_req", 32'(o_stb_inst), 32'd0);
        repeat (8) step(0, 0, 0, 0, 0);

        // Slow bus with two requests in flight, then a branch: stale acks must vanish.
        min_lat = 3; max_lat = 3;
        for (int i = 0; i < 10 && bus.size() != 2; i++) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h0000_0200);
        found = 0; first = '0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(0, 0, 0, 0, 0);
            if (s_ce) begin found = 1; first = s_pc; end
        end
        chk("branch_seen", 32'(found), 32'd1);
        chk("branch_first_pc", first, 32'h0000_0200);

        // Trap and branch together: trap target wins.
        step(0, 1, 32'h0000_0080, 1, 32'h0000_0300);
        chk("wb_priority", o_iaddr, 32'h0000_0080);
        repeat (10) step(0, 0, 0, 0, 0);

        // Back-to-back redirects with requests in flight, and a redirect while stalled.
        step(0, 0, 0, 1, 32'h0000_0500);
        step(0, 1, 32'h0000_0600, 0, 0);
        repeat (8) step(1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 32'h0000_0400);
        repeat (12) step(0, 0, 0, 0, 0);

        // Address wrap at the top of the 32-bit space.
        min_lat = 1; max_lat = 2;
        step(0, 0, 0, 1, 32'hFFFF_FFF8);
        repeat (12) step(0, 0, 0, 0, 0);

        // Random mix of latency, ack gaps, stalls and redirects.
        min_lat = 1; max_lat = 4; ack_pct = 70;
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(99) < 25,
                 $urandom_range(99) < 2, $urandom & 32'hFFFF_FFFC,
                 $urandom_range(99) < 3, $urandom & 32'hFFFF_FFFC);
        end

        // Fill the buffer, then reset asynchronously mid-stream.
        min_lat = 1; max_lat = 1; ack_pct = 100;
        repeat (12) step(1, 0, 0, 0, 0);
        chk("prereset_count", 32'(o_count), DEPTH);
        i_ack_inst = 1'b0;
        i_stall    = 1'b0;
        i_rst_n    = 1'b0;
        #1;
        chk("arst_ce",    32'(o_ce), 32'd0);
        chk("arst_count", 32'(o_count), 32'd0);
        chk("arst_pc",    o_pc, 32'd0);
        chk("arst_inst",  o_inst, 32'd0);
        chk("arst_stb",   32'(o_stb_inst), 32'd0);
        chk("arst_iaddr", o_iaddr, PCR);
        bus.delete();
        buf_q.delete();
        fetch_addr = PCR;
        epoch++;
        @(posedge clk);
        #1;
        i_rst_n = 1'b1;
        repeat (12) step(0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
